// File: rtl/axis_detector_writer.sv
// axis_detector_writer: replays {time, pattern} stream words onto a
// 64-bit detector bus when a free-running timer reaches each time.
module axis_detector_writer (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [4:0]   cfg_data,
  output logic [31:0]  sts_data,
  output logic [63:0]  det_data,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PULSE
  } state_t;

  state_t      state;
  logic        run;
  logic        live;
  logic        accept;
  logic        due;
  logic        late;
  logic        late_hit;
  logic [3:0]  width_m1;
  logic [3:0]  cnt;
  logic [63:0] timer;
  logic [63:0] evt_time;
  logic [63:0] evt_pat;
  logic [31:0] late_cnt;

  assign run      = cfg_data[4];
  assign width_m1 = cfg_data[3:0];
  assign due      = evt_time <= timer;
  assign late     = evt_time < timer;
  assign accept   = s_axis_tvalid & s_axis_tready;

  // live holds tready low during reset even when run is already set
  assign s_axis_tready = live & run & (state == IDLE);
  assign sts_data      = late_cnt;

  assign late_hit = run & (state == WAIT) & late;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer <= '0;
    end else if (!run) begin
      timer <= '0;
    end else begin
      timer <= timer + 64'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      live     <= 1'b0;
      evt_time <= '0;
      evt_pat  <= '0;
      cnt      <= '0;
      det_data <= '0;
    end else begin
      live <= 1'b1;
      if (!run) begin
        state    <= IDLE;
        cnt      <= '0;
        det_data <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              evt_time <= s_axis_tdata[127:64];
              evt_pat  <= s_axis_tdata[63:0];
              state    <= WAIT;
            end
          end
          WAIT: begin
            // width is frozen here so a cfg change cannot stretch a pulse
            if (due) begin
              det_data <= evt_pat;
              cnt      <= width_m1;
              state    <= PULSE;
            end
          end
          PULSE: begin
            if (cnt == 4'd0) begin
              det_data <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            det_data <= '0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      late_cnt <= '0;
    end else if (late_hit && (late_cnt != 32'hFFFF_FFFF)) begin
      late_cnt <= late_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_detector_writer.sv
// tb_axis_detector_writer: directed and randomized playback checks
// against a timeline model of accepts, waits and pulses.
module tb_axis_detector_writer;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [4:0]   cfg;
  logic [31:0]  sts_data;
  logic [63:0]  det_data;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;

  int checks = 0;
  int errors = 0;

  longint unsigned tm;
  longint unsigned exp_sts;

  int              n_ev;
  longint unsigned w_cur;
  longint unsigned ev_t[16];
  logic [63:0]     ev_p[16];
  longint unsigned ev_gap[16];
  longint unsigned m_acc[16];
  longint unsigned m_play[16];
  longint unsigned m_late;

  longint unsigned rec_tm[1024];
  logic [63:0]     rec_det[1024];
  logic            rec_rdy[1024];
  int              nrec;
  int              drv_acc;

  axis_detector_writer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg),
    .sts_data      (sts_data),
    .det_data      (det_data),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready)
  );

  always #5 aclk = ~aclk;

  // Timeline model: each event is accepted when both offered and free,
  // waits until its time (or plays at once if late), then pulses W cycles.
  function automatic void build_model();
    longint unsigned free_t;
    longint unsigned vfrom;
    m_late = 0;
    free_t = 0;
    for (int i = 0; i < n_ev; i++) begin
      vfrom = (i == 0) ? ev_gap[0] : m_acc[i-1] + 1 + ev_gap[i];
      m_acc[i] = (vfrom > free_t) ? vfrom : free_t;
      m_play[i] = (ev_t[i] > m_acc[i] + 1) ? ev_t[i] : m_acc[i] + 1;
      if (ev_t[i] < m_acc[i] + 1) m_late++;
      free_t = m_play[i] + w_cur + 1;
    end
  endfunction

  function automatic logic [63:0] exp_det(input longint unsigned t);
    exp_det = '0;
    for (int i = 0; i < n_ev; i++)
      if (t > m_play[i] && t <= m_play[i] + w_cur) exp_det = ev_p[i];
  endfunction

  function automatic logic exp_rdy(input longint unsigned t);
    exp_rdy = 1'b1;
    for (int i = 0; i < n_ev; i++)
      if (t >= m_acc[i] + 1 && t <= m_play[i] + w_cur) exp_rdy = 1'b0;
  endfunction

  function automatic longint unsigned sat_add(
    input longint unsigned a, input longint unsigned b);
    longint unsigned s;
    s = a + b;
    sat_add = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
  endfunction

  task automatic step();
    @(posedge aclk);
    if (!aresetn || !cfg[4]) tm = 0;
    else tm = tm + 1;
    @(negedge aclk);
  endtask

  task automatic restart(input logic [4:0] c);
    tvalid = 1'b0;
    cfg = {1'b0, c[3:0]};
    step();
    cfg = c;
  endtask

  task automatic drive_seq(input int ncyc);
    int i;
    longint unsigned acc_prev;
    longint unsigned vfrom;
    i = 0;
    acc_prev = 0;
    nrec = 0;
    for (int c = 0; c < ncyc; c++) begin
      vfrom = (i == 0) ? ev_gap[0] : acc_prev + 1 + ev_gap[i];
      tvalid = (i < n_ev) && (tm >= vfrom);
      if (tvalid) tdata = {ev_t[i], ev_p[i]};
      else tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      rec_tm[nrec] = tm;
      rec_det[nrec] = det_data;
      rec_rdy[nrec] = tready;
      nrec++;
      if (tvalid && tready) begin
        acc_prev = tm;
        i++;
      end
      step();
    end
    tvalid = 1'b0;
    drv_acc = i;
  endtask

  task automatic test_reset();
    logic [63:0] pat;
    aresetn = 1'b0;
    cfg = 5'h13;
    tvalid = 1'b0;
    tdata = '0;
    tm = 0;
    exp_sts = 0;
    @(negedge aclk);
    step();
    #1;
    checks++;
    if (tready !== 1'b0) begin
      errors++; $display("FAIL reset_rdy got %b exp 0", tready);
    end
    checks++;
    if (det_data !== 64'd0) begin
      errors++; $display("FAIL reset_det got %h exp 0", det_data);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    restart(5'h13);
    pat = {$urandom(), $urandom()} | 64'h1;
    w_cur = 4; n_ev = 1;
    ev_t[0] = 0; ev_p[0] = pat; ev_gap[0] = 0;
    build_model();
    drive_seq(4);
    #1;
    checks++;
    if (det_data !== exp_det(tm)) begin
      errors++; $display("FAIL reset_prepulse got %h exp %h", det_data, exp_det(tm));
    end
    checks++;
    if (sts_data !== 32'd1) begin
      errors++; $display("FAIL reset_prelate got %0d exp 1", sts_data);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (det_data !== 64'd0 || tready !== 1'b0 || sts_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_async got det=%h rdy=%b sts=%0d exp 0/0/0",
               det_data, tready, sts_data);
    end
    @(negedge aclk);
    tm = 0;
    aresetn = 1'b1;
    exp_sts = 0;
    w_cur = 4; n_ev = 1;
    ev_t[0] = 20; ev_p[0] = {$urandom(), $urandom()} | 64'h2; ev_gap[0] = 3;
    build_model();
    drive_seq(28);
    for (int k = 0; k < nrec; k++) begin
      checks++;
      if (rec_det[k] !== exp_det(rec_tm[k])) begin
        errors++;
        $display("FAIL reset_restart det tm=%0d got %h exp %h",
                 rec_tm[k], rec_det[k], exp_det(rec_tm[k]));
      end
    end
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL reset_restart sts got %0d exp %0d", sts_data, exp_sts);
    end
  endtask

  task automatic test_on_time();
    restart(5'h13);
    w_cur = 4; n_ev = 1;
    ev_t[0] = 100; ev_p[0] = 64'h0000_0000_0001_8000; ev_gap[0] = 10;
    build_model();
    drive_seq(112);
    for (int k = 0; k < nrec; k++) begin
      checks++;
      if (rec_det[k] !== exp_det(rec_tm[k])) begin
        errors++;
        $display("FAIL on_time det tm=%0d got %h exp %h",
                 rec_tm[k], rec_det[k], exp_det(rec_tm[k]));
      end
      checks++;
      if (rec_rdy[k] !== exp_rdy(rec_tm[k])) begin
        errors++;
        $display("FAIL on_time rdy tm=%0d got %b exp %b",
                 rec_tm[k], rec_rdy[k], exp_rdy(rec_tm[k]));
      end
    end
    checks++;
    if (drv_acc != n_ev) begin
      errors++; $display("FAIL on_time accepted got %0d exp %0d", drv_acc, n_ev);
    end
    exp_sts = sat_add(exp_sts, m_late);
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL on_time sts got %0d exp %0d", sts_data, exp_sts);
    end
  endtask

  task automatic test_late();
    restart(5'h13);
    w_cur = 4; n_ev = 1;
    ev_t[0] = 5; ev_p[0] = {$urandom(), $urandom()} | 64'h4; ev_gap[0] = 50;
    build_model();
    drive_seq(60);
    for (int k = 0; k < nrec; k++) begin
      checks++;
      if (rec_det[k] !== exp_det(rec_tm[k])) begin
        errors++;
        $display("FAIL late det tm=%0d got %h exp %h",
                 rec_tm[k], rec_det[k], exp_det(rec_tm[k]));
      end
    end
    exp_sts = sat_add(exp_sts, m_late);
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL late sts got %0d exp %0d", sts_data, exp_sts);
    end
  endtask

  task automatic test_back_to_back();
    restart(5'h10);
    w_cur = 1; n_ev = 3;
    ev_t[0] = 200; ev_t[1] = 203; ev_t[2] = 204;
    for (int i = 0; i < 3; i++) begin
      ev_p[i] = {$urandom(), $urandom()} | 64'h8;
      ev_gap[i] = 0;
    end
    build_model();
    drive_seq(int'(m_play[2] + w_cur + 4));
    for (int k = 0; k < nrec; k++) begin
      checks++;
      if (rec_det[k] !== exp_det(rec_tm[k]) || rec_rdy[k] !== exp_rdy(rec_tm[k])) begin
        errors++;
        $display("FAIL b2b tm=%0d got det=%h rdy=%b exp det=%h rdy=%b",
                 rec_tm[k], rec_det[k], rec_rdy[k],
                 exp_det(rec_tm[k]), exp_rdy(rec_tm[k]));
      end
    end
    exp_sts = sat_add(exp_sts, m_late);
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL b2b sts got %0d exp %0d", sts_data, exp_sts);
    end
  endtask

  task automatic test_width_latch();
    restart(5'h13);
    w_cur = 4; n_ev = 1;
    ev_t[0] = 10; ev_p[0] = {$urandom(), $urandom()} | 64'h10; ev_gap[0] = 0;
    build_model();
    drive_seq(12);
    cfg = 5'h10;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (det_data !== exp_det(tm) || tready !== exp_rdy(tm)) begin
        errors++;
        $display("FAIL width_latch tm=%0d got det=%h rdy=%b exp det=%h rdy=%b",
                 tm, det_data, tready, exp_det(tm), exp_rdy(tm));
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [3:0] w4;
    longint unsigned base;
    for (int r = 0; r < 6; r++) begin
      w4 = 4'($urandom_range(0, 15));
      restart({1'b1, w4});
      w_cur = 64'(w4) + 64'd1;
      n_ev = int'($urandom_range(3, 6));
      base = 64'($urandom_range(0, 20));
      for (int i = 0; i < n_ev; i++) begin
        if ($urandom_range(0, 3) == 0) ev_t[i] = 64'($urandom_range(0, 32'(base)));
        else ev_t[i] = base;
        base = base + 64'($urandom_range(0, 32'(w_cur) + 4));
        ev_p[i] = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom(), $urandom()};
        ev_gap[i] = 64'($urandom_range(0, 3));
      end
      build_model();
      drive_seq(int'(m_play[n_ev-1] + w_cur + 4));
      for (int k = 0; k < nrec; k++) begin
        checks++;
        if (rec_det[k] !== exp_det(rec_tm[k]) || rec_rdy[k] !== exp_rdy(rec_tm[k])) begin
          errors++;
          $display("FAIL random r=%0d tm=%0d got det=%h rdy=%b exp det=%h rdy=%b",
                   r, rec_tm[k], rec_det[k], rec_rdy[k],
                   exp_det(rec_tm[k]), exp_rdy(rec_tm[k]));
        end
      end
      checks++;
      if (drv_acc != n_ev) begin
        errors++; $display("FAIL random accepted got %0d exp %0d", drv_acc, n_ev);
      end
      exp_sts = sat_add(exp_sts, m_late);
      checks++;
      if (sts_data !== exp_sts[31:0]) begin
        errors++; $display("FAIL random sts got %0d exp %0d", sts_data, exp_sts);
      end
    end
  endtask

  task automatic test_run_drop();
    restart(5'h03);
    tvalid = 1'b1;
    tdata = {64'd3, 64'hDEAD_BEEF_0000_0001};
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (tready !== 1'b0) begin
        errors++; $display("FAIL bp_rdy got %b exp 0", tready);
      end
      step();
    end
    tvalid = 1'b0;
    cfg = 5'h13;
    #1;
    checks++;
    if (tready !== 1'b1 || det_data !== 64'd0) begin
      errors++; $display("FAIL bp_noaccept got rdy=%b det=%h exp 1/0", tready, det_data);
    end
    tvalid = 1'b1;
    tdata = {64'd1000, 64'hFFFF_0000_FFFF_0000};
    step();
    tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (tready !== 1'b0 || det_data !== 64'd0) begin
        errors++; $display("FAIL drop_wait got rdy=%b det=%h exp 0/0", tready, det_data);
      end
      step();
    end
    cfg = 5'h03;
    step();
    cfg = 5'h13;
    w_cur = 4; n_ev = 1;
    ev_t[0] = 8; ev_p[0] = {$urandom(), $urandom()} | 64'h20; ev_gap[0] = 0;
    build_model();
    drive_seq(15);
    for (int k = 0; k < nrec; k++) begin
      checks++;
      if (rec_det[k] !== exp_det(rec_tm[k]) || rec_rdy[k] !== exp_rdy(rec_tm[k])) begin
        errors++;
        $display("FAIL drop_restart tm=%0d got det=%h rdy=%b exp det=%h rdy=%b",
                 rec_tm[k], rec_det[k], rec_rdy[k],
                 exp_det(rec_tm[k]), exp_rdy(rec_tm[k]));
      end
    end
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL drop_sts got %0d exp %0d", sts_data, exp_sts);
    end
    restart(5'h17);
    w_cur = 8; n_ev = 1;
    ev_t[0] = 3; ev_p[0] = {$urandom(), $urandom()} | 64'h40; ev_gap[0] = 0;
    build_model();
    drive_seq(6);
    #1;
    checks++;
    if (det_data !== exp_det(tm)) begin
      errors++; $display("FAIL drop_pulse_pre got %h exp %h", det_data, exp_det(tm));
    end
    cfg = 5'h07;
    step();
    #1;
    checks++;
    if (det_data !== 64'd0 || tready !== 1'b0) begin
      errors++; $display("FAIL drop_pulse got det=%h rdy=%b exp 0/0", det_data, tready);
    end
    cfg = 5'h17;
    #1;
    checks++;
    if (tready !== 1'b1) begin
      errors++; $display("FAIL drop_idle rdy got %b exp 1", tready);
    end
  endtask

  task automatic test_saturation();
    force dut.late_cnt = 32'hFFFF_FFFD;
    step();
    release dut.late_cnt;
    exp_sts = 64'hFFFF_FFFD;
    #1;
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL sat_preload got %h exp %h", sts_data, exp_sts[31:0]);
    end
    restart(5'h10);
    w_cur = 1; n_ev = 4;
    for (int i = 0; i < 4; i++) begin
      ev_t[i] = 0;
      ev_p[i] = {$urandom(), $urandom()};
      ev_gap[i] = 0;
    end
    build_model();
    drive_seq(int'(m_play[3] + w_cur + 3));
    exp_sts = sat_add(exp_sts, m_late);
    checks++;
    if (sts_data !== exp_sts[31:0]) begin
      errors++; $display("FAIL sat_hold got %h exp %h", sts_data, exp_sts[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_on_time();
    test_late();
    test_back_to_back();
    test_width_latch();
    test_random();
    test_run_drop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
